// File: rtl/csram_arbiter_if.sv
// Beat-level request/response bundle between one requester and the CSRAM arbiter.
interface csram_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, wdata, wen, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, wen, output gnt, rvalid, rdata);
endinterface

// File: rtl/csram_arbiter.sv
// Two-port beat arbiter for the single-port CSRAM: owner-sticky grant with a bounded
// hold, one registered issue stage, and a per-port read tag pipe for returning data.
module csram_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csram_arbiter_if.slave        m0_io,
  csram_arbiter_if.slave        m1_io,
  output logic                  csram_cen,
  output logic [31:0]           csram_addr,
  output logic [31:0]           csram_d,
  output logic [3:0]            csram_wen,
  input  logic [31:0]           csram_q
);
  localparam int unsigned       HOLD_W   = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic              owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              gnt0_c, gnt1_c, accept_c, sel_c, win1_c;
  logic [31:0]       sel_addr_c, sel_wdata_c;
  logic [3:0]        sel_wen_c;
  logic              issue_port_q;
  logic [RD_LATENCY-1:0][1:0] tag_q;  // one-hot port tag per stage, 0 for writes/idle
  logic [1:0]        tag_in_c;

  // Grant: a lone requester always wins; under contention the owner keeps it until the hold runs out
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    win1_c = (hold_q < HOLD_MAX) ? owner_q : !owner_q;
    if (m0_io.req && m1_io.req) begin
      gnt1_c = win1_c;
      gnt0_c = !win1_c;
    end else begin
      gnt0_c = m0_io.req;
      gnt1_c = m1_io.req;
    end
  end

  assign accept_c    = gnt0_c | gnt1_c;
  assign sel_c       = gnt1_c;
  assign sel_addr_c  = sel_c ? m1_io.addr  : m0_io.addr;
  assign sel_wdata_c = sel_c ? m1_io.wdata : m0_io.wdata;
  assign sel_wen_c   = sel_c ? m1_io.wen   : m0_io.wen;

  // Ownership bookkeeping; an idle cycle clears the hold but keeps the owner
  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (accept_c) begin
      if (sel_c == owner_q) begin
        if (hold_q < HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
      end else begin
        owner_d = sel_c;
        hold_d  = HOLD_W'(1);
      end
    end else begin
      hold_d = '0;
    end
  end

  assign tag_in_c = (csram_cen && (csram_wen == 4'h0)) ? (issue_port_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q      <= 1'b0;
      hold_q       <= '0;
      csram_cen    <= 1'b0;
      csram_wen    <= 4'h0;
      csram_addr   <= 32'h0;
      csram_d      <= 32'h0;
      issue_port_q <= 1'b0;
      tag_q        <= '0;
    end else begin
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      csram_cen <= accept_c;
      csram_wen <= accept_c ? sel_wen_c : 4'h0;
      if (accept_c) begin
        csram_addr   <= sel_addr_c & 32'hFFFF_FFFC;
        csram_d      <= sel_wdata_c;
        issue_port_q <= sel_c;
      end
      tag_q[0] <= tag_in_c;
      for (int i = 1; i < int'(RD_LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign m0_io.gnt    = gnt0_c;
  assign m1_io.gnt    = gnt1_c;
  assign m0_io.rvalid = tag_q[RD_LATENCY-1][0];
  assign m1_io.rvalid = tag_q[RD_LATENCY-1][1];
  assign m0_io.rdata  = csram_q;
  assign m1_io.rdata  = csram_q;
endmodule

// File: tb/tb_csram_arbiter.sv
// Self-checking bench for csram_arbiter: directed scenarios plus a random soak against
// a memory/arbitration reference model.
module tb_csram_arbiter;
  localparam int LAT  = 2;
  localparam int MAXH = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csram_cen;
  logic [31:0] csram_addr, csram_d, csram_q;
  logic [3:0]  csram_wen;

  always #5 clk = ~clk;

  csram_arbiter_if p0 ();
  csram_arbiter_if p1 ();

  csram_arbiter #(.RD_LATENCY(LAT), .MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .rst_i(rst_n), .m0_io(p0), .m1_io(p1),
    .csram_cen(csram_cen), .csram_addr(csram_addr), .csram_d(csram_d),
    .csram_wen(csram_wen), .csram_q(csram_q)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hCAFE_0000 : (32'h5A00_0000 ^ (32'(i) * 32'h0001_0101));
  endfunction

  // Environment CSRAM with LAT-cycle read latency
  logic [31:0] sram    [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
    end else if (csram_cen) begin
      if (csram_wen != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (csram_wen[b]) sram[csram_addr[9:2]][8*b +: 8] <= csram_d[8*b +: 8];
      end else begin
        rd_pipe[0] <= sram[csram_addr[9:2]];
      end
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign csram_q = rd_pipe[LAT-1];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ref_owner = 0;
  int          ref_streak = 0;
  logic [31:0] ref_mem [256];
  exp_t        q0[$];
  exp_t        q1[$];

  function automatic logic [1:0] pred_gnt();
    if (p0.req && p1.req) begin
      int w;
      w = (ref_streak < MAXH) ? ref_owner : 1 - ref_owner;
      return (w == 1) ? 2'b10 : 2'b01;
    end
    return {p1.req, p0.req};
  endfunction

  task automatic set_req(input int p, input logic r, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
    if (p == 0) begin
      p0.req = r; p0.addr = a; p0.wen = w; p0.wdata = d;
    end else begin
      p1.req = r; p1.addr = a; p1.wen = w; p1.wdata = d;
    end
  endtask

  // Apply the predicted accept of this cycle to the reference, then move to the next cycle
  task automatic advance();
    logic [1:0]  g;
    logic [31:0] a, d;
    logic [3:0]  w;
    int          p, idx;
    g = pred_gnt();
    if (g != 2'b00) begin
      p   = g[1] ? 1 : 0;
      a   = (p == 1) ? p1.addr  : p0.addr;
      d   = (p == 1) ? p1.wdata : p0.wdata;
      w   = (p == 1) ? p1.wen   : p0.wen;
      idx = int'(a[9:2]);
      if (w != 4'h0) begin
        for (int b = 0; b < 4; b++) if (w[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else if (p == 0) q0.push_back('{ref_mem[idx], cyc + 1 + LAT});
      else q1.push_back('{ref_mem[idx], cyc + 1 + LAT});
      if (p == ref_owner) ref_streak++;
      else begin
        ref_owner  = p;
        ref_streak = 1;
      end
    end else if (!p0.req && !p1.req) begin
      ref_streak = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (n) advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (csram_cen !== 1'b0 || csram_wen !== 4'h0 || csram_addr !== 32'h0 || csram_d !== 32'h0)
      begin failures++; $display("FAIL reset_state cen=%b wen=%h addr=%h d=%h required all 0", csram_cen, csram_wen, csram_addr, csram_d); end
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0044, 4'h0, 32'h1234_5678);
    #1;
    checks++;
    if (p0.gnt !== 1'b1) begin failures++; $display("FAIL reset_launch_gnt got=%b required=1", p0.gnt); end
    advance();
    set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
    checks++;
    if (csram_cen !== 1'b1 || csram_addr !== 32'h44)
      begin failures++; $display("FAIL reset_inflight_issue cen=%b addr=%h required 1/00000044", csram_cen, csram_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (csram_cen !== 1'b0 || csram_wen !== 4'h0 || csram_addr !== 32'h0 || csram_d !== 32'h0 ||
        p0.rvalid !== 1'b0 || p1.rvalid !== 1'b0)
      begin failures++; $display("FAIL reset_async cen=%b wen=%h addr=%h d=%h rv=%b%b required all 0", csram_cen, csram_wen, csram_addr, csram_d, p1.rvalid, p0.rvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    ref_owner = 0; ref_streak = 0;
    q0.delete(); q1.delete();
    for (int k = 0; k < LAT + 3; k++) begin
      checks++;
      if (p0.rvalid !== 1'b0 || p1.rvalid !== 1'b0)
        begin failures++; $display("FAIL reset_dropped_read k=%0d rvalid=%b%b required 00", k, p1.rvalid, p0.rvalid); end
      advance();
    end
    set_req(0, 1'b1, 32'h0000_0100, 4'h0, 32'h0);
    set_req(1, 1'b1, 32'h0000_0200, 4'h0, 32'h0);
    #1;
    checks++;
    if ({p1.gnt, p0.gnt} !== 2'b01)
      begin failures++; $display("FAIL reset_first_tie gnt=%b required=01", {p1.gnt, p0.gnt}); end
    advance();
    idle(LAT + 2);
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 32'h0000_0013, 4'h0, $urandom);
    #1;
    checks++;
    if ({p1.gnt, p0.gnt} !== 2'b01)
      begin failures++; $display("FAIL single_gnt gnt=%b required=01", {p1.gnt, p0.gnt}); end
    advance();
    set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
    checks++;
    if (csram_cen !== 1'b1 || csram_addr !== 32'h10 || csram_wen !== 4'h0)
      begin failures++; $display("FAIL single_issue cen=%b addr=%h wen=%h required 1/00000010/0", csram_cen, csram_addr, csram_wen); end
    for (int k = 1; k <= LAT; k++) begin
      advance();
      checks++;
      if (p0.rvalid !== (k == LAT) || p1.rvalid !== 1'b0)
        begin failures++; $display("FAIL single_rvalid k=%0d rv=%b%b required %b%b", k, p1.rvalid, p0.rvalid, 1'b0, (k == LAT)); end
    end
    checks++;
    if (p0.rdata !== 32'hCAFE_0000 || p1.rdata !== 32'hCAFE_0000)
      begin failures++; $display("FAIL single_rdata m0=%h m1=%h required=cafe0000", p0.rdata, p1.rdata); end
    idle(2);
  endtask

  task automatic test_contention();
    int exp_tbl [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int obs;
    for (int i = 0; i < 16; i++) begin
      set_req(1, 1'b1, 32'(i) << 2, 4'h0, 32'h0);
      set_req(0, (i > 0), 32'h0000_0080, 4'h0, 32'h0);
      #1;
      obs = p1.gnt ? 1 : (p0.gnt ? 0 : -1);
      checks++;
      if ((p0.gnt & p1.gnt) !== 1'b0 || obs != exp_tbl[i])
        begin failures++; $display("FAIL contention cycle=%0d granted=%0d required=%0d", i, obs, exp_tbl[i]); end
      advance();
    end
    idle(LAT + 2);
  endtask

  task automatic test_write_then_read();
    set_req(1, 1'b1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({p1.gnt, p0.gnt} !== 2'b10)
      begin failures++; $display("FAIL wr_gnt gnt=%b required=10", {p1.gnt, p0.gnt}); end
    advance();
    set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(0, 1'b1, 32'h0000_0020, 4'h0, 32'h0);
    checks++;
    if (csram_cen !== 1'b1 || csram_wen !== 4'hF || csram_addr !== 32'h20 || csram_d !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL wr_issue cen=%b wen=%h addr=%h d=%h required 1/f/00000020/deadbeef", csram_cen, csram_wen, csram_addr, csram_d); end
    #1;
    checks++;
    if ({p1.gnt, p0.gnt} !== 2'b01)
      begin failures++; $display("FAIL rd_gnt gnt=%b required=01", {p1.gnt, p0.gnt}); end
    advance();
    set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
    checks++;
    if (csram_cen !== 1'b1 || csram_wen !== 4'h0 || csram_addr !== 32'h20)
      begin failures++; $display("FAIL rd_issue cen=%b wen=%h addr=%h required 1/0/00000020", csram_cen, csram_wen, csram_addr); end
    repeat (LAT) advance();
    checks++;
    if (p0.rvalid !== 1'b1 || p1.rvalid !== 1'b0 || p0.rdata !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL raw_data rv=%b%b data=%h required 01/deadbeef", p1.rvalid, p0.rvalid, p0.rdata); end
    idle(2);
  endtask

  task automatic test_idle_gap();
    int exp_tbl [5] = '{0, 0, 0, 0, 1};
    int obs;
    for (int i = 0; i < MAXH; i++) begin
      set_req(0, 1'b1, 32'h0000_0040, 4'h0, 32'h0);
      #1;
      checks++;
      if ({p1.gnt, p0.gnt} !== 2'b01)
        begin failures++; $display("FAIL gap_m0_beat i=%0d gnt=%b required=01", i, {p1.gnt, p0.gnt}); end
      advance();
    end
    idle(1);
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 32'h0000_0044, 4'h0, 32'h0);
      set_req(1, 1'b1, 32'h0000_0048, 4'h0, 32'h0);
      #1;
      obs = p1.gnt ? 1 : (p0.gnt ? 0 : -1);
      checks++;
      if (obs != exp_tbl[i])
        begin failures++; $display("FAIL gap_after_idle i=%0d granted=%0d required=%0d", i, obs, exp_tbl[i]); end
      advance();
    end
    idle(LAT + 2);
  endtask

  task automatic test_soak();
    logic       pend [2];
    int         wait_c [2];
    int         dens;
    logic [1:0] g_exp, g_obs;
    logic       exp_v;
    idle(LAT + 2);
    q0.delete(); q1.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
    wait_c[0] = 0; wait_c[1] = 0;
    for (int n = 0; n < 10000 + LAT + 3; n++) begin
      // Returned reads must match the model's data, port and due cycle
      exp_v = (q0.size() > 0) && (q0[0].due <= cyc);
      checks++;
      if (p0.rvalid !== exp_v) begin failures++; $display("FAIL soak_rvalid0 cyc=%0d got=%b required=%b", cyc, p0.rvalid, exp_v); end
      if (exp_v) begin
        checks++;
        if (p0.rdata !== q0[0].data) begin failures++; $display("FAIL soak_rdata0 cyc=%0d got=%h required=%h", cyc, p0.rdata, q0[0].data); end
        void'(q0.pop_front());
      end
      exp_v = (q1.size() > 0) && (q1[0].due <= cyc);
      checks++;
      if (p1.rvalid !== exp_v) begin failures++; $display("FAIL soak_rvalid1 cyc=%0d got=%b required=%b", cyc, p1.rvalid, exp_v); end
      if (exp_v) begin
        checks++;
        if (p1.rdata !== q1[0].data) begin failures++; $display("FAIL soak_rdata1 cyc=%0d got=%h required=%h", cyc, p1.rdata, q1[0].data); end
        void'(q1.pop_front());
      end
      dens = ((n / 2000) % 2 == 1) ? 95 : 45;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && n < 10000 && $urandom_range(0, 99) < dens) begin
          pend[p] = 1'b1;
          set_req(p, 1'b1, {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
                  ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
        end else if (!pend[p]) begin
          set_req(p, 1'b0, 32'h0, 4'h0, 32'h0);
        end
      end
      #1;
      g_exp = pred_gnt();
      g_obs = {p1.gnt, p0.gnt};
      checks++;
      if (g_obs !== g_exp) begin failures++; $display("FAIL soak_gnt cyc=%0d got=%b required=%b", cyc, g_obs, g_exp); end
      checks++;
      if (g_obs === 2'b11) begin failures++; $display("FAIL soak_double_gnt cyc=%0d got=11 required one-hot", cyc); end
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && !g_obs[p]) wait_c[p]++;
        else wait_c[p] = 0;
        if (g_obs[p]) pend[p] = 1'b0;
        checks++;
        if (wait_c[p] > MAXH) begin failures++; $display("FAIL soak_wait port=%0d waited=%0d limit=%0d", p, wait_c[p], MAXH); end
      end
      advance();
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0)
      begin failures++; $display("FAIL soak_drain outstanding=%0d/%0d required=0/0", q0.size(), q1.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_idle_gap();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
